// File: rtl/reg_dump_pkg.sv
// ----------------------------------------------------------------------------
// reg_dump_pkg
// Shared types and default sizing for the register-dump block.
//   - state_t   : FSM state encoding used by reg_dump
//   - NREGS_DEF : default number of registers walked
//   - AW_DEF    : default register address width
//   - DW_DEF    : default register data width
// Optional feature macro: REG_DUMP_CHECKSUM_EN (adds the CSUM state).
// ----------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        DONE = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/reg_dump_csum.sv
// ----------------------------------------------------------------------------
// reg_dump_csum
// Running XOR of every accepted data beat of a dump. Only present when the
// REG_DUMP_CHECKSUM_EN macro is defined; otherwise this file is empty.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the checksum
//   clear - clears the checksum (asserted when a dump starts)
//   en    - fold din into the checksum this cycle
//   din   - beat payload being accepted
//   csum  - current checksum value
// ----------------------------------------------------------------------------
`ifdef REG_DUMP_CHECKSUM_EN
module reg_dump_csum
    import reg_dump_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] csum
);

    logic [DW-1:0] csum_q;
    logic [DW-1:0] csum_d;

    // Clear wins over accumulate so a new dump always starts from zero.
    always_comb begin
        csum_d = csum_q;
        if (clear) begin
            csum_d = '0;
        end else if (en) begin
            csum_d = csum_q ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule
`endif

// File: rtl/reg_dump.sv
// ----------------------------------------------------------------------------
// reg_dump
// Walks registers 0..NREGS-1 of an external register file and streams each
// one out over a valid/ready interface, then pulses done.
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   start                - one-cycle request to begin a dump (IDLE only)
//   abort                - cancel the dump in progress, no done pulse
//   rd_addr / rd_data    - combinational register-file read port
//   dout_valid/ready     - stream handshake
//   dout_data/idx/last   - beat payload, register index, final-beat flag
//   busy                 - high whenever the FSM is not IDLE
//   done                 - one-cycle pulse after the final beat is accepted
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends a checksum beat
// (XOR of all data beats) with dout_idx 0 and dout_last 1.
// ----------------------------------------------------------------------------
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic [AW-1:0] dout_idx,
    output logic          dout_last,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state_q,      state_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic          dout_valid_q, dout_valid_d;
    logic [DW-1:0] dout_data_q,  dout_data_d;
    logic [AW-1:0] dout_idx_q,   dout_idx_d;
    logic          dout_last_q,  dout_last_d;
    logic          handshake;

    assign handshake = dout_valid_q & dout_ready;

`ifdef REG_DUMP_CHECKSUM_EN
    logic          csum_clear;
    logic          csum_en;
    logic [DW-1:0] csum_value;

    // Only register beats feed the checksum; the checksum beat itself does not.
    assign csum_clear = (state_q == IDLE) && start && !abort;
    assign csum_en    = (state_q == SEND) && handshake;

    reg_dump_csum #(
        .DW (DW)
    ) u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clear),
        .en    (csum_en),
        .din   (dout_data_q),
        .csum  (csum_value)
    );
`endif

    // Next-state and beat-register logic. Abort overrides everything else
    // outside IDLE, including a handshake on the same cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_idx_d   = dout_idx_q;
        dout_last_d  = dout_last_q;

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            idx_d        = '0;
            dout_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    dout_data_d  = rd_data;
                    dout_idx_d   = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
                    dout_last_d  = 1'b0;
`else
                    dout_last_d  = (idx_q == LAST_IDX);
`endif
                    dout_valid_d = 1'b1;
                    state_d      = SEND;
                end
                SEND: begin
                    if (handshake) begin
                        dout_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = DONE;
`endif
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = LOAD;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                // First CSUM cycle captures the finished checksum (which now
                // includes the final register beat); the rest wait for accept.
                CSUM: begin
                    if (!dout_valid_q) begin
                        dout_data_d  = csum_value;
                        dout_idx_d   = '0;
                        dout_last_d  = 1'b1;
                        dout_valid_d = 1'b1;
                    end else if (handshake) begin
                        dout_valid_d = 1'b0;
                        state_d      = DONE;
                    end
                end
`endif
                DONE: begin
                    dout_valid_d = 1'b0;
                    state_d      = IDLE;
                end
                default: begin
                    state_d      = IDLE;
                    dout_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_idx_q   <= '0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_idx_q   <= dout_idx_d;
            dout_last_q  <= dout_last_d;
        end
    end

    // The read address is only meaningful while a register is being loaded.
    assign rd_addr    = (state_q == LOAD) ? idx_q : '0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign dout_idx   = dout_idx_q;
    assign dout_last  = dout_last_q;

endmodule
